// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets one requester at a time write bursts of up to
// G_BURST beats into a downstream FIFO, with one idle bubble between grants.
module fifo_write_arbiter #(
  parameter int unsigned G_WIDTH = 8,
  parameter int unsigned G_NREQ  = 4,
  parameter int unsigned G_BURST = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [G_NREQ-1:0]           i_req_valid,
  input  logic [G_NREQ*G_WIDTH-1:0]   i_req_data,
  output logic [G_NREQ-1:0]           o_req_ready,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_wr,
  output logic [G_WIDTH-1:0]          o_fifo_data,
  output logic [G_NREQ-1:0]           o_grant,
  output logic                        o_busy
);

  localparam int unsigned IDX_W = (G_NREQ > 1) ? $clog2(G_NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(G_BURST + 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t             state, state_nxt;
  logic [G_NREQ-1:0]  grant, grant_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   last, last_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_nxt;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  // Round-robin search starting one past the previous grantee
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last;
    cand       = '0;
    for (int unsigned i = 1; i <= G_NREQ; i++) begin
      cand = IDX_W'((32'(last) + i) % G_NREQ);
      if (!pick_found && i_req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      gidx     <= '0;
      last     <= IDX_W'(G_NREQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      gidx     <= gidx_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Next state plus the combinational handshake toward requesters and FIFO
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    gidx_nxt    = gidx;
    last_nxt    = last;
    beat_nxt    = beat_cnt;
    o_req_ready = '0;
    o_fifo_wr   = 1'b0;
    o_fifo_data = '0;

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = ST_GRANT;
          grant_nxt = G_NREQ'(1) << pick_idx;
          gidx_nxt  = pick_idx;
          beat_nxt  = '0;
        end
      end
      ST_GRANT: begin
        o_req_ready = i_fifo_full ? '0 : grant;
        o_fifo_wr   = i_req_valid[gidx] && !i_fifo_full;
        o_fifo_data = i_req_data[32'(gidx)*G_WIDTH +: G_WIDTH];
        if (!i_req_valid[gidx]) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          last_nxt  = gidx;
        end else if (!i_fifo_full) begin
          beat_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == CNT_W'(G_BURST - 1)) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            last_nxt  = gidx;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign o_grant = grant;
  assign o_busy  = (state == ST_GRANT);

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter G_WIDTH, default 8, data width in bits per requester and toward the FIFO.
REQ-002 The block SHALL have parameter G_NREQ, default 4, number of requesters (2..16).
REQ-003 The block SHALL have parameter G_BURST, default 4, maximum beats per grant (1..255).
REQ-004 The block SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port i_req_valid  input  G_NREQ  per-requester data valid.
REQ-007 The block SHALL have port i_req_data  input  G_NREQ*G_WIDTH  requester k data in bits [k*G_WIDTH +: G_WIDTH].
REQ-008 The block SHALL have port o_req_ready  output  G_NREQ  per-requester accept; a beat transfers when valid and ready are both high on a rising edge.
REQ-009 The block SHALL have port i_fifo_full  input  1  full flag of the downstream FIFO write port.
REQ-010 The block SHALL have port o_fifo_wr  output  1  write enable to the FIFO.
REQ-011 The block SHALL have port o_fifo_data  output  G_WIDTH  write data to the FIFO.
REQ-012 The block SHALL have port o_grant  output  G_NREQ  one-hot current grantee; all zero when idle.
REQ-013 The block SHALL have port o_busy  output  1  high while in state GRANT.

Function
REQ-014 The FSM SHALL have two states, IDLE and GRANT.
REQ-015 In IDLE with any i_req_valid high, the block SHALL select the first valid requester in round-robin order starting at (last_grantee+1) mod G_NREQ, register it in o_grant, clear beat_cnt, and enter GRANT next cycle (one-cycle arbitration latency).
REQ-016 In IDLE with no valid requester, the block SHALL stay in IDLE with o_grant all zero.
REQ-017 In GRANT, o_req_ready[g] SHALL equal !i_fifo_full for grantee g, combinationally; all other o_req_ready bits SHALL be 0.
REQ-018 o_fifo_wr SHALL equal i_req_valid[g] && o_req_ready[g] in GRANT, else 0; o_fifo_data SHALL equal i_req_data of g in GRANT, else 0.
REQ-019 Each transfer SHALL increment the beat counter (width ceil(log2(G_BURST+1))); i_fifo_full high SHALL stall with grant and counter held, no write, no timeout.
REQ-020 GRANT SHALL release to IDLE, recording last_grantee=g, on the edge where the transfer that makes beat_cnt reach G_BURST occurs.
REQ-021 GRANT SHALL also release to IDLE when i_req_valid[g] is low at a rising edge (requester ended early), without a write that cycle.
REQ-022 After a release there SHALL be exactly one IDLE cycle (one bubble) before the next grant.
REQ-023 Changes of non-granted i_req_valid bits SHALL NOT affect the current grant.
REQ-024 o_fifo_wr SHALL never assert while i_fifo_full is high; o_grant SHALL be one-hot or zero at all times.

Reset
REQ-025 Reset assertion SHALL immediately, independent of i_clk, force state IDLE, o_grant=0, o_busy=0, o_req_ready=0, o_fifo_wr=0, o_fifo_data=0, beat_cnt=0, last_grantee=G_NREQ-1 (first priority to requester 0).
REQ-026 Reset assertion mid-burst SHALL abort the burst with no write; beats already written are not recalled.
REQ-027 After deassertion, first arbitration SHALL occur on the first rising edge with i_rst_n high.

Verification
REQ-028 Reset then i_req_valid=4'b1111, full=0 -> o_grant=0001 one cycle later, 4 writes, bubble, then 0010, 0100, 1000, 0001 in turn.
REQ-029 Only requester 2 valid for 10 beats, G_BURST=4 -> bursts of 4,4,2, each separated by one IDLE cycle, all o_grant=0100.
REQ-030 Requester 1 granted, i_fifo_full high for 3 cycles after beat 2 -> o_fifo_wr=0 and ready=0 during stall, beats 3-4 complete after full drops, release after beat 4.
REQ-031 Requester 3 granted, drops valid after 1 beat -> release next edge, next grant goes to first valid from requester 0.
REQ-032 i_rst_n low mid-burst between clock edges -> all outputs 0 immediately; after release, requester 0 has priority.
REQ-033 Random valid/full traffic with a scoreboard against a model FIFO -> per-requester data order preserved, no write while full, o_grant always one-hot or zero.
